// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator for the load/store path: one CPU request becomes one
// bus cycle, with lane steering on stores and lane extraction/extension on loads.
module wb_lsu_master #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   // CPU request side
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   // CPU response side
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   // Wishbone initiator
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_adr,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic [3:0]            wb_sel,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic                  wb_ack,
   input  logic                  wb_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_size;
   logic [1:0]       r_off;
   logic             r_unsigned;
   logic             r_we;

   logic [1:0]            w_off;
   logic                  w_misaligned;
   logic [3:0]            w_sel;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic                  w_timeout;

   assign w_off     = req_addr[1:0];
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Alignment/legality of the incoming request
   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         SZ_BYTE: w_misaligned = 1'b0;
         SZ_HALF: w_misaligned = req_addr[0];
         SZ_WORD: w_misaligned = (w_off != 2'b00);
         default: w_misaligned = 1'b1;
      endcase
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      w_sel   = 4'b1111;
      w_wdata = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            w_sel   = 4'b0001 << w_off;
            w_wdata = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_sel   = 4'b0011 << w_off;
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_sel   = 4'b1111;
            w_wdata = req_wdata;
         end
      endcase
   end

   // Lane extraction and sign/zero extension of read data
   always_comb begin
      w_byte = wb_dat_i[7:0];
      case (r_off)
         2'd0:    w_byte = wb_dat_i[7:0];
         2'd1:    w_byte = wb_dat_i[15:8];
         2'd2:    w_byte = wb_dat_i[23:16];
         default: w_byte = wb_dat_i[31:24];
      endcase
      w_half = r_off[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
      case (r_size)
         SZ_BYTE: w_load_data = {{(DATA_WIDTH-8){~r_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: w_load_data = {{(DATA_WIDTH-16){~r_unsigned & w_half[15]}}, w_half};
         default: w_load_data = wb_dat_i;
      endcase
   end

   // Control FSM with registered bus and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_size     <= SZ_BYTE;
         r_off      <= 2'b00;
         r_unsigned <= 1'b0;
         r_we       <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         wb_cyc     <= 1'b0;
         wb_stb     <= 1'b0;
         wb_we      <= 1'b0;
         wb_adr     <= '0;
         wb_dat_o   <= '0;
         wb_sel     <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_size     <= req_size;
                  r_off      <= w_off;
                  r_unsigned <= req_unsigned;
                  r_we       <= req_we;
                  r_cnt      <= '0;
                  req_ready  <= 1'b0;
                  if (w_misaligned) begin
                     // Rejected requests never touch the bus
                     r_state    <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     r_state  <= S_BUS;
                     wb_cyc   <= 1'b1;
                     wb_stb   <= 1'b1;
                     wb_we    <= req_we;
                     wb_adr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     wb_dat_o <= w_wdata;
                     wb_sel   <= w_sel;
                  end
               end
            end

            S_BUS: begin
               if (wb_err || wb_ack || w_timeout) begin
                  r_state    <= S_RESP;
                  wb_cyc     <= 1'b0;
                  wb_stb     <= 1'b0;
                  resp_valid <= 1'b1;
                  // Error takes priority over a simultaneous ack
                  if (wb_err) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (wb_ack) begin
                     resp_err   <= 1'b0;
                     resp_rdata <= r_we ? '0 : w_load_data;
                  end else begin
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_RESP: begin
               r_state    <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end

            default: begin
               r_state    <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               wb_cyc     <= 1'b0;
               wb_stb     <= 1'b0;
            end
         endcase
      end
   end

endmodule
